oled_frame_sequencer: RTL
=========================

// Module: oled_frame_sequencer
// PURPOSE
//  Sequences the SPI byte master for the SSD1306-class 128x64 OLED: drives panel
//  hardware reset, streams a fixed 25-byte init command list, then on each refresh
//  request sends per-page address commands plus 128 framebuffer bytes for all 8 pages.
//  Sits between the display framebuffer RAM and the SPI master (spi_send/spi_send_done).
// PARAMETERS
//  RST_CYCLES   20000  cycles oled_res held low, then again held high before init
//  PAGES        8      display pages per frame
//  COLS         128    bytes per page
//  TIMEOUT      4096   max cycles waiting for spi_send_done before abort
// PORTS
//  clk            in   1   system clock
//  rst            in   1   async reset, active-high
//  refresh        in   1   1-cycle pulse: request full-frame redraw
//  oled_res       out  1   panel reset pin, active-low
//  spi_data_out   out  8   byte to SPI master
//  dc             out  1   to SPI master dc_in; 0=command, 1=data
//  spi_send       out  1   1-cycle pulse: SPI master start byte
//  spi_send_done  in   1   1-cycle pulse from SPI master: byte shifted out
//  fb_addr        out  10  framebuffer read address = page*COLS+col
//  fb_data        in   8   framebuffer read data, valid 1 cycle after fb_addr
//  init_done      out  1   high once init list fully sent; cleared by rst/abort
//  busy           out  1   high in every state except IDLE
//  frame_done     out  1   1-cycle pulse after last data byte's spi_send_done
//  timeout_err    out  1   sticky; set on abort, cleared by rst only
// BEHAVIOUR
//  Reset values: oled_res=0, spi_data_out=0, dc=0, spi_send=0, fb_addr=0,
//   init_done=0, busy=1, frame_done=0, timeout_err=0; state=RES_LO, counters 0.
//  States: RES_LO -> RES_HI -> INIT -> IDLE -> PAGE_CMD -> FETCH -> DATA -> ...
//  RES_LO: oled_res=0 for RST_CYCLES; RES_HI: oled_res=1 for RST_CYCLES; -> INIT.
//  Byte send (all byte states): present spi_data_out/dc, assert spi_send exactly
//   one cycle, then wait for spi_send_done; spi_data_out/dc stable from pulse to
//   done. Next spi_send no earlier than cycle after done. Never two bytes in flight.
//  INIT: dc=0, ROM bytes in order: AE D5 80 A8 3F D3 00 40 8D 14 20 02 A1 C8 DA 12
//   81 CF D9 F1 DB 40 A4 A6 AF (25). After 25th done: init_done=1 -> IDLE.
//  IDLE: on pending refresh -> PAGE_CMD with page=0, busy=1.
//  PAGE_CMD: dc=0, bytes B0+page, 00, 10 -> FETCH (col=0).
//  FETCH: fb_addr=page*COLS+col; latch fb_data next cycle -> DATA.
//  DATA: dc=1, send latched byte. On done: col==COLS-1 ? (page==PAGES-1 ?
//   frame_done pulse, -> IDLE : page+1, -> PAGE_CMD) : col+1, -> FETCH.
//  Frame = PAGES*(3+COLS) = 1048 bytes. fb_addr wraps never (max 1023).
//  refresh: latched into 1-bit pending flag in any state; refresh while busy or
//   before init_done is held and serviced from IDLE; multiple -> one frame.
//   Pending cleared when leaving IDLE for PAGE_CMD; refresh in that same
//   cycle re-sets it (new frame follows).
//  Timeout: wait counter reset at each spi_send; reaching TIMEOUT without done ->
//   timeout_err=1, init_done=0, pending kept, -> RES_LO (full re-init).
//  spi_send_done outside a wait is ignored.
//  rst mid-frame: immediate return to reset values; no partial byte reissued.
// TESTING
//  rst then run with RST_CYCLES=10 -> oled_res 0 for 10 cyc, 1 for 10 cyc, then
//   25 cmd bytes AE..AF with dc=0, init_done rises after 25th done.
//  SPI model done 8 cyc after send; fb[i]=i[7:0]; refresh -> 1048 bytes, page 3
//   header B3 00 10, data 80..FF with dc=1, frame_done pulse once, busy falls.
//  refresh pulsed 3x during frame -> exactly one extra frame afterwards.
//  refresh asserted during RES_HI -> frame starts right after init_done.
//  Model withholds done on byte 500 with TIMEOUT=64 -> timeout_err=1 after 64
//   cyc, oled_res low, init replayed, pending frame then completes.
//  rst asserted mid-DATA -> all outputs at reset values same cycle (async).

Source files
------------

// File: rtl/oled_frame_sequencer.sv
// OLED frame sequencer for an SSD1306-class 128x64 panel.
// Drives the panel reset pin, streams the init command list through the SPI
// byte master, then on each refresh request sends every page (address header
// plus framebuffer bytes). One byte is in flight at a time; a stalled byte
// aborts back to a full panel re-init.
module oled_frame_sequencer #(
    parameter int unsigned RST_CYCLES = 20000,
    parameter int unsigned PAGES      = 8,
    parameter int unsigned COLS       = 128,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    output logic       oled_res,
    output logic [7:0] spi_data_out,
    output logic       dc,
    output logic       spi_send,
    input  logic       spi_send_done,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       init_done,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam int unsigned RW       = $clog2(RST_CYCLES + 1);
    localparam int unsigned WW       = $clog2(TIMEOUT + 1);
    localparam int unsigned PW       = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned INIT_LEN = 25;

    localparam logic [2:0] RES_LO   = 3'd0;
    localparam logic [2:0] RES_HI   = 3'd1;
    localparam logic [2:0] INIT     = 3'd2;
    localparam logic [2:0] IDLE     = 3'd3;
    localparam logic [2:0] PAGE_CMD = 3'd4;
    localparam logic [2:0] FETCH    = 3'd5;
    localparam logic [2:0] DATA     = 3'd6;

    logic [2:0]    state, state_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [4:0]    byte_idx, byte_idx_n;
    logic [PW-1:0] page, page_n;
    logic [CW-1:0] col, col_n;
    logic          in_flight, in_flight_n;
    logic [7:0]    data_lat, data_lat_n;
    logic          pending, pending_n;

    logic          oled_res_n;
    logic [7:0]    spi_data_out_n;
    logic          dc_n;
    logic          spi_send_n;
    logic [9:0]    fb_addr_n;
    logic          init_done_n;
    logic          busy_n;
    logic          frame_done_n;
    logic          timeout_err_n;

    logic [7:0]    tx_byte;
    logic          tx_dc;
    logic          byte_done;
    logic          abort;

    // Panel power-up command list, sent in order with dc=0.
    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    init_byte = 8'hAE;
            5'd1:    init_byte = 8'hD5;
            5'd2:    init_byte = 8'h80;
            5'd3:    init_byte = 8'hA8;
            5'd4:    init_byte = 8'h3F;
            5'd5:    init_byte = 8'hD3;
            5'd6:    init_byte = 8'h00;
            5'd7:    init_byte = 8'h40;
            5'd8:    init_byte = 8'h8D;
            5'd9:    init_byte = 8'h14;
            5'd10:   init_byte = 8'h20;
            5'd11:   init_byte = 8'h02;
            5'd12:   init_byte = 8'hA1;
            5'd13:   init_byte = 8'hC8;
            5'd14:   init_byte = 8'hDA;
            5'd15:   init_byte = 8'h12;
            5'd16:   init_byte = 8'h81;
            5'd17:   init_byte = 8'hCF;
            5'd18:   init_byte = 8'hD9;
            5'd19:   init_byte = 8'hF1;
            5'd20:   init_byte = 8'hDB;
            5'd21:   init_byte = 8'h40;
            5'd22:   init_byte = 8'hA4;
            5'd23:   init_byte = 8'hA6;
            5'd24:   init_byte = 8'hAF;
            default: init_byte = 8'h00;
        endcase
    endfunction

    // Linear framebuffer address of (page, col).
    function automatic logic [9:0] addr_of(input logic [PW-1:0] p, input logic [CW-1:0] c);
        addr_of = 10'(32'(p) * COLS + 32'(c));
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RES_LO;
            rst_cnt      <= '0;
            wait_cnt     <= '0;
            byte_idx     <= '0;
            page         <= '0;
            col          <= '0;
            in_flight    <= 1'b0;
            data_lat     <= '0;
            pending      <= 1'b0;
            oled_res     <= 1'b0;
            spi_data_out <= '0;
            dc           <= 1'b0;
            spi_send     <= 1'b0;
            fb_addr      <= '0;
            init_done    <= 1'b0;
            busy         <= 1'b1;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            rst_cnt      <= rst_cnt_n;
            wait_cnt     <= wait_cnt_n;
            byte_idx     <= byte_idx_n;
            page         <= page_n;
            col          <= col_n;
            in_flight    <= in_flight_n;
            data_lat     <= data_lat_n;
            pending      <= pending_n;
            oled_res     <= oled_res_n;
            spi_data_out <= spi_data_out_n;
            dc           <= dc_n;
            spi_send     <= spi_send_n;
            fb_addr      <= fb_addr_n;
            init_done    <= init_done_n;
            busy         <= busy_n;
            frame_done   <= frame_done_n;
            timeout_err  <= timeout_err_n;
        end
    end

    // Next-state, byte handshake and output computation.
    always_comb begin
        state_n        = state;
        rst_cnt_n      = rst_cnt;
        wait_cnt_n     = wait_cnt;
        byte_idx_n     = byte_idx;
        page_n         = page;
        col_n          = col;
        in_flight_n    = in_flight;
        data_lat_n     = data_lat;
        pending_n      = pending | refresh;
        oled_res_n     = oled_res;
        spi_data_out_n = spi_data_out;
        dc_n           = dc;
        spi_send_n     = 1'b0;
        fb_addr_n      = fb_addr;
        init_done_n    = init_done;
        frame_done_n   = 1'b0;
        timeout_err_n  = timeout_err;
        tx_byte        = 8'h00;
        tx_dc          = 1'b0;
        byte_done      = 1'b0;
        abort          = 1'b0;

        // Byte presented by the current byte-sending state.
        case (state)
            INIT: tx_byte = init_byte(byte_idx);
            PAGE_CMD: begin
                case (byte_idx)
                    5'd0:    tx_byte = 8'hB0 + 8'(page);
                    5'd1:    tx_byte = 8'h00;
                    default: tx_byte = 8'h10;
                endcase
            end
            DATA: begin
                tx_byte = data_lat;
                tx_dc   = 1'b1;
            end
            default: tx_byte = 8'h00;
        endcase

        // Issue one byte, then wait for its done or give up after TIMEOUT cycles.
        if (state == INIT || state == PAGE_CMD || state == DATA) begin
            if (!in_flight) begin
                spi_send_n     = 1'b1;
                spi_data_out_n = tx_byte;
                dc_n           = tx_dc;
                in_flight_n    = 1'b1;
                wait_cnt_n     = '0;
            end else if (spi_send_done) begin
                in_flight_n = 1'b0;
                byte_done   = 1'b1;
            end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                abort = 1'b1;
            end else begin
                wait_cnt_n = wait_cnt + WW'(1);
            end
        end

        case (state)
            RES_LO: begin
                oled_res_n = 1'b0;
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    rst_cnt_n  = '0;
                    oled_res_n = 1'b1;
                    state_n    = RES_HI;
                end else begin
                    rst_cnt_n = rst_cnt + RW'(1);
                end
            end
            RES_HI: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    rst_cnt_n  = '0;
                    byte_idx_n = '0;
                    state_n    = INIT;
                end else begin
                    rst_cnt_n = rst_cnt + RW'(1);
                end
            end
            INIT: begin
                if (byte_done) begin
                    if (byte_idx == 5'(INIT_LEN - 1)) begin
                        init_done_n = 1'b1;
                        byte_idx_n  = '0;
                        state_n     = IDLE;
                    end else begin
                        byte_idx_n = byte_idx + 5'd1;
                    end
                end
            end
            IDLE: begin
                if (pending) begin
                    // A refresh in this same cycle keeps the flag set for a follow-on frame.
                    pending_n  = refresh;
                    page_n     = '0;
                    byte_idx_n = '0;
                    state_n    = PAGE_CMD;
                end
            end
            PAGE_CMD: begin
                if (byte_done) begin
                    if (byte_idx == 5'd2) begin
                        col_n      = '0;
                        byte_idx_n = '0;
                        fb_addr_n  = addr_of(page, '0);
                        state_n    = FETCH;
                    end else begin
                        byte_idx_n = byte_idx + 5'd1;
                    end
                end
            end
            FETCH: begin
                // fb_addr is already on the bus; RAM data is valid one cycle later.
                if (byte_idx == 5'd0) begin
                    byte_idx_n = 5'd1;
                end else begin
                    data_lat_n = fb_data;
                    byte_idx_n = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (byte_done) begin
                    byte_idx_n = '0;
                    if (col == CW'(COLS - 1)) begin
                        if (page == PW'(PAGES - 1)) begin
                            frame_done_n = 1'b1;
                            state_n      = IDLE;
                        end else begin
                            page_n  = page + PW'(1);
                            state_n = PAGE_CMD;
                        end
                    end else begin
                        col_n     = col + CW'(1);
                        fb_addr_n = addr_of(page, col + CW'(1));
                        state_n   = FETCH;
                    end
                end
            end
            default: state_n = RES_LO;
        endcase

        // Stalled SPI byte: drop the frame, flag it, and re-init the panel.
        if (abort) begin
            state_n       = RES_LO;
            rst_cnt_n     = '0;
            byte_idx_n    = '0;
            in_flight_n   = 1'b0;
            oled_res_n    = 1'b0;
            init_done_n   = 1'b0;
            timeout_err_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

endmodule
